ysyx_lsu: RTL and testbench
===========================

YSYX_LSU -- requirements
Module: ysyx_lsu

Interface
REQ-001 SHALL have parameter BIT_W, default 32, meaning data/address width.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port exu_avalid  input  1  access request from execute stage, held until completion pulse.
REQ-005 SHALL have port exu_ren / exu_wen  input  1 each  load / store select.
REQ-006 SHALL have port exu_addr  input  BIT_W  byte address.
REQ-007 SHALL have port exu_wdata  input  BIT_W  store data, right-aligned.
REQ-008 SHALL have port exu_func3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port rdata_o  output  BIT_W  aligned, extended load data; rvalid_o  output  1  load done pulse; wready_o  output  1  store done pulse; fault_o  output  1  access fault, valid with either done pulse.
REQ-010 SHALL have bus master ports: araddr/arvalid/arready, rdata/rresp[1:0]/rvalid/rready, awaddr/awvalid/awready, wdata/wstrb[3:0]/wvalid/wready, bresp[1:0]/bvalid/bready; AXI4-Lite semantics.

Function
REQ-011 SHALL implement FSM states IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
REQ-012 SHALL accept a request only in IDLE when exu_avalid=1; addr, wdata, func3, ren/wen latched that cycle.
REQ-013 SHALL detect misalignment (H with addr[0]=1, W with addr[1:0]!=0) at accept; misaligned -> DONE directly, no bus traffic, fault_o=1, rdata_o=0.
REQ-014 SHALL, for loads, go IDLE->RADDR with arvalid=1, araddr=latched addr; hold until arready; then RDATA with rready=1 until rvalid.
REQ-015 SHALL, for stores, go IDLE->WREQ asserting awvalid and wvalid together; each deasserts independently on its handshake; WREQ->WRESP when both done (same cycle or different cycles).
REQ-016 SHALL hold bready=1 in WRESP and advance to DONE on bvalid.
REQ-017 SHALL shift store data left by 8*addr[1:0]; wstrb: B 4'b0001<<addr[1:0], H 4'b0011<<addr[1:0], W 4'b1111.
REQ-018 SHALL shift load data right by 8*addr[1:0], then sign-extend (B,H) or zero-extend (BU,HU) to BIT_W; W passes through.
REQ-019 SHALL register rdata_o from bus rdata at the rvalid handshake; rdata_o holds until next load completes.
REQ-020 SHALL pulse rvalid_o (load) or wready_o (store) for exactly one cycle in DONE, then return to IDLE; never both high.
REQ-021 SHALL set fault_o=1 when rresp or bresp != 2'b00; fault_o valid only during the done pulse.
REQ-022 SHALL ignore exu_avalid in every state except IDLE; a request present in the cycle after DONE is accepted as new.
REQ-023 SHALL treat exu_ren=exu_wen=1 as a load; exu_ren=exu_wen=0 with avalid keeps FSM in IDLE.
REQ-024 SHALL keep bus address/data/strobe outputs stable while the matching valid is high and not accepted.
REQ-025 SHALL give minimum load latency 3 cycles accept->rvalid_o (arready and rvalid high immediately), store 3 cycles likewise.

Reset
REQ-026 SHALL on rst=1 enter IDLE and drive arvalid, rready, awvalid, wvalid, bready, rvalid_o, wready_o, fault_o = 0, rdata_o = 0.
REQ-027 SHALL abandon any in-flight transaction on reset mid-operation; no done pulse results from it.

Verification
REQ-028 LW addr 0x8000_0004, bus rdata 0xDEAD_BEEF, zero-wait slave -> rvalid_o one cycle, rdata_o=0xDEAD_BEEF, fault_o=0, latency 3.
REQ-029 LB addr 0x8000_0003, bus rdata 0x80FF_0000 -> rdata_o=0xFFFF_FF80; same with LBU -> 0x0000_0080.
REQ-030 SH addr 0x8000_0002, wdata 0x0000_1234, awready delayed 2 cycles after wready -> wdata bus 0x1234_0000, wstrb 4'b1100, one wready_o pulse after bvalid.
REQ-031 LW addr 0x8000_0002 -> no arvalid ever, rvalid_o=1, fault_o=1, rdata_o=0.
REQ-032 SW with bresp=2'b10 -> wready_o=1 with fault_o=1; rst asserted during RDATA -> all bus valids 0 next cycle, no rvalid_o.

Source files
------------

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: load/store unit bridging the execute stage to an AXI4-Lite master port.
// Handles sub-word alignment, strobes, sign/zero extension and access faults.
module ysyx_lsu #(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exu_avalid,
    input  logic             exu_ren,
    input  logic             exu_wen,
    input  logic [BIT_W-1:0] exu_addr,
    input  logic [BIT_W-1:0] exu_wdata,
    input  logic [2:0]       exu_func3,
    output logic [BIT_W-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             wready_o,
    output logic             fault_o,
    output logic [BIT_W-1:0] araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [BIT_W-1:0] rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    output logic [BIT_W-1:0] awaddr,
    output logic             awvalid,
    input  logic             awready,
    output logic [BIT_W-1:0] wdata,
    output logic [3:0]       wstrb,
    output logic             wvalid,
    input  logic             wready,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready
);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;
    state_t           state_q;
    logic [BIT_W-1:0] addr_q, wdata_q, rshift, rext;
    logic [2:0]       func3_q;
    logic             is_load, is_store, misaligned;

    always_comb begin
        is_load    = exu_ren;
        is_store   = exu_wen & ~exu_ren;
        misaligned = (exu_func3[1:0] == 2'b01 && exu_addr[0]) ||
                     (exu_func3[1:0] == 2'b10 && exu_addr[1:0] != 2'b00);
        rshift     = rdata >> {addr_q[1:0], 3'b000};
        // func3[2] selects the unsigned variants, so it masks the sign bit
        rext       = func3_q[1:0] == 2'b00 ? {{(BIT_W-8){~func3_q[2] & rshift[7]}}, rshift[7:0]} :
                     func3_q[1:0] == 2'b01 ? {{(BIT_W-16){~func3_q[2] & rshift[15]}}, rshift[15:0]} :
                     rshift;
    end

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign wdata  = wdata_q << {addr_q[1:0], 3'b000};
    assign wstrb  = func3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                    func3_q[1:0] == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            func3_q  <= '0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            rvalid_o <= 1'b0;
            wready_o <= 1'b0;
            fault_o  <= 1'b0;
            rdata_o  <= '0;
        end else begin
            case (state_q)
                IDLE: if (exu_avalid && (exu_ren || exu_wen)) begin
                    addr_q  <= exu_addr;
                    wdata_q <= exu_wdata;
                    func3_q <= exu_func3;
                    if (misaligned) begin
                        state_q  <= DONE;
                        rvalid_o <= is_load;
                        wready_o <= is_store;
                        fault_o  <= 1'b1;
                        if (is_load) rdata_o <= '0;
                    end else if (is_load) begin
                        state_q <= RADDR;
                        arvalid <= 1'b1;
                    end else begin
                        state_q <= WREQ;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end
                end
                RADDR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state_q <= RDATA;
                end
                RDATA: if (rvalid) begin
                    rready   <= 1'b0;
                    rdata_o  <= rext;
                    fault_o  <= rresp != 2'b00;
                    rvalid_o <= 1'b1;
                    state_q  <= DONE;
                end
                WREQ: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready) wvalid <= 1'b0;
                    // address and data may complete in either order
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready  <= 1'b1;
                        state_q <= WRESP;
                    end
                end
                WRESP: if (bvalid) begin
                    bready   <= 1'b0;
                    fault_o  <= bresp != 2'b00;
                    wready_o <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    rvalid_o <= 1'b0;
                    wready_o <= 1'b0;
                    fault_o  <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_lsu.sv
// tb_ysyx_lsu: directed scoreboard bench for ysyx_lsu against a latency-programmable AXI4-Lite slave.
module tb_ysyx_lsu;
    logic        clk = 0, rst = 1;
    logic        exu_avalid = 0, exu_ren = 0, exu_wen = 0;
    logic [31:0] exu_addr = 0, exu_wdata = 0;
    logic [2:0]  exu_func3 = 0;
    logic [31:0] rdata_o, araddr, rdata, awaddr, wdata;
    logic        rvalid_o, wready_o, fault_o, arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    ysyx_lsu #(.BIT_W(32)) dut (
        .clk(clk), .rst(rst), .exu_avalid(exu_avalid), .exu_ren(exu_ren), .exu_wen(exu_wen),
        .exu_addr(exu_addr), .exu_wdata(exu_wdata), .exu_func3(exu_func3),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .wready_o(wready_o), .fault_o(fault_o),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int          lat_ar = 0, lat_r = 0, lat_aw = 0, lat_w = 0, lat_b = 0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int          ar_seen = 0, aw_seen = 0, cyc = 0;
    logic [31:0] s_rdata = 0;
    logic [1:0]  s_rresp = 0, s_bresp = 0;

    assign arready = arvalid && ar_cnt >= lat_ar;
    assign rvalid  = rready && r_cnt >= lat_r;
    assign rdata   = rvalid ? s_rdata : 32'h0;
    assign rresp   = s_rresp;
    assign awready = awvalid && aw_cnt >= lat_aw;
    assign wready  = wvalid && w_cnt >= lat_w;
    assign bvalid  = bready && b_cnt >= lat_b;
    assign bresp   = s_bresp;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ar_cnt  <= (arvalid && !arready) ? ar_cnt + 1 : 0;
        r_cnt   <= (rready && !rvalid) ? r_cnt + 1 : 0;
        aw_cnt  <= (awvalid && !awready) ? aw_cnt + 1 : 0;
        w_cnt   <= (wvalid && !wready) ? w_cnt + 1 : 0;
        b_cnt   <= (bready && !bvalid) ? b_cnt + 1 : 0;
        ar_seen <= ar_seen + (arvalid ? 1 : 0);
        aw_seen <= aw_seen + ((awvalid || wvalid) ? 1 : 0);
    end

    typedef struct {bit ld; logic [31:0] rd; bit flt; int acc; int lat;} exp_t;
    exp_t        expq[$];
    logic [31:0] arq[$];
    logic [35:0] wq[$];
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic miss(input string n);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not expected / not seen (cycle %0d)", n, cyc);
    endtask

    // Monitor: done pulses against the scoreboard, bus beats against the bus queues.
    logic        aw_hold = 0;
    logic [31:0] aw_prev = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid_o && wready_o) miss("both_done_pulses");
            if (rvalid_o || wready_o) begin
                if (expq.size() == 0) miss("unexpected_done");
                else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("done_kind", {31'b0, rvalid_o}, {31'b0, e.ld});
                    chk("fault", {31'b0, fault_o}, {31'b0, e.flt});
                    if (e.ld) chk("rdata_o", rdata_o, e.rd);
                    if (e.lat != 0) chk("latency", cyc - e.acc, e.lat);
                end
            end
            if (arvalid && arready) begin
                if (arq.size() == 0) miss("unexpected_ar");
                else chk("araddr", araddr, arq.pop_front());
            end
            if (wvalid && wready) begin
                if (wq.size() == 0) miss("unexpected_w");
                else begin
                    logic [35:0] w;
                    w = wq.pop_front();
                    chk("wdata", wdata, w[31:0]);
                    chk("wstrb", {28'b0, wstrb}, {28'b0, w[35:32]});
                end
            end
            if (aw_hold && awvalid) chk("awaddr_stable", awaddr, aw_prev);
        end
        aw_hold = awvalid && !awready;
        aw_prev = awaddr;
    end

    task automatic req(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input bit e_ld, input logic [31:0] e_rd,
                       input bit e_flt, input int lat, input bit chain);
        int k;
        exu_ren = ld; exu_wen = st; exu_addr = a; exu_wdata = wd; exu_func3 = f3; exu_avalid = 1;
        expq.push_back('{e_ld, e_rd, e_flt, chain ? cyc + 1 : cyc, lat});
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(rvalid_o || wready_o) && k < 40);
        if (k >= 40) miss("done_timeout");
    endtask

    task automatic chk_quiet(input string n);
        chk({n, "_arvalid"}, {31'b0, arvalid}, 0);
        chk({n, "_rready"}, {31'b0, rready}, 0);
        chk({n, "_awvalid"}, {31'b0, awvalid}, 0);
        chk({n, "_wvalid"}, {31'b0, wvalid}, 0);
        chk({n, "_bready"}, {31'b0, bready}, 0);
        chk({n, "_rvalid_o"}, {31'b0, rvalid_o}, 0);
        chk({n, "_wready_o"}, {31'b0, wready_o}, 0);
        chk({n, "_fault_o"}, {31'b0, fault_o}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_ar, base_aw, k;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset_rdata_o", rdata_o, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        // LW zero-wait
        s_rdata = 32'hDEAD_BEEF;
        arq.push_back(32'h8000_0004);
        req(1, 0, 32'h8000_0004, 0, 3'b010, 1, 32'hDEAD_BEEF, 0, 3, 0);
        exu_avalid = 0;
        @(negedge clk);
        // LB / LBU / LH / LHU on upper bytes
        s_rdata = 32'h80FF_0000;
        arq.push_back(32'h8000_0003);
        req(1, 0, 32'h8000_0003, 0, 3'b000, 1, 32'hFFFF_FF80, 0, 3, 0);
        exu_avalid = 0;
        @(negedge clk);
        arq.push_back(32'h8000_0003);
        req(1, 0, 32'h8000_0003, 0, 3'b100, 1, 32'h0000_0080, 0, 3, 0);
        exu_avalid = 0;
        @(negedge clk);
        arq.push_back(32'h8000_0002);
        req(1, 0, 32'h8000_0002, 0, 3'b001, 1, 32'hFFFF_80FF, 0, 3, 0);
        exu_avalid = 0;
        @(negedge clk);
        arq.push_back(32'h8000_0002);
        req(1, 0, 32'h8000_0002, 0, 3'b101, 1, 32'h0000_80FF, 0, 3, 0);
        exu_avalid = 0;
        @(negedge clk);
        // SH with awready two cycles after wready
        lat_aw = 2;
        wq.push_back({4'b1100, 32'h1234_0000});
        req(0, 1, 32'h8000_0002, 32'h0000_1234, 3'b001, 0, 0, 0, 5, 0);
        exu_avalid = 0;
        lat_aw = 0;
        @(negedge clk);
        // SB, then SW chained straight after the done pulse
        wq.push_back({4'b0010, 32'h0000_AB00});
        req(0, 1, 32'h8000_0001, 32'h0000_00AB, 3'b000, 0, 0, 0, 3, 0);
        wq.push_back({4'b1111, 32'hCAFE_F00D});
        req(0, 1, 32'h8000_0000, 32'hCAFE_F00D, 3'b010, 0, 0, 0, 3, 1);
        exu_avalid = 0;
        chk("rdata_hold", rdata_o, 32'h0000_80FF);
        @(negedge clk);
        // misaligned LW: no bus traffic
        base_ar = ar_seen;
        req(1, 0, 32'h8000_0002, 0, 3'b010, 1, 32'h0, 1, 1, 0);
        exu_avalid = 0;
        @(negedge clk);
        chk("misaligned_lw_no_ar", ar_seen - base_ar, 0);
        // misaligned SH
        base_aw = aw_seen;
        req(0, 1, 32'h8000_0001, 32'h5555, 3'b001, 0, 0, 1, 1, 0);
        exu_avalid = 0;
        @(negedge clk);
        chk("misaligned_sh_no_aw", aw_seen - base_aw, 0);
        // SW with error response, then LW with error response chained
        s_bresp = 2'b10;
        wq.push_back({4'b1111, 32'h0BAD_0BAD});
        req(0, 1, 32'h8000_0010, 32'h0BAD_0BAD, 3'b010, 0, 0, 1, 3, 0);
        s_bresp = 2'b00;
        s_rresp = 2'b11;
        s_rdata = 32'h1234_5678;
        arq.push_back(32'h8000_0020);
        req(1, 0, 32'h8000_0020, 0, 3'b010, 1, 32'h1234_5678, 1, 3, 1);
        exu_avalid = 0;
        s_rresp = 2'b00;
        @(negedge clk);
        // ren=wen=1 is a load, with slow slave
        lat_ar = 1; lat_r = 2;
        s_rdata = 32'h0000_7F00;
        arq.push_back(32'h8000_0031);
        req(1, 1, 32'h8000_0031, 32'hFFFF_FFFF, 3'b000, 1, 32'h0000_007F, 0, 6, 0);
        exu_avalid = 0;
        lat_ar = 0; lat_r = 0;
        @(negedge clk);
        // avalid with neither ren nor wen stays idle
        base_ar = ar_seen;
        base_aw = aw_seen;
        exu_ren = 0; exu_wen = 0; exu_avalid = 1;
        repeat (4) @(negedge clk);
        exu_avalid = 0;
        chk("no_op_idle", (ar_seen - base_ar) + (aw_seen - base_aw), 0);
        // reset during RDATA abandons the load
        lat_r = 5;
        s_rdata = 32'h1111_2222;
        arq.push_back(32'h8000_0040);
        exu_ren = 1; exu_wen = 0; exu_addr = 32'h8000_0040; exu_func3 = 3'b010; exu_avalid = 1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rready && k < 20);
        if (k >= 20) miss("rready_timeout");
        exu_avalid = 0;
        rst = 1;
        @(posedge clk);
        #1;
        chk_quiet("midreset");
        @(negedge clk);
        rst = 0;
        lat_r = 0;
        repeat (6) @(negedge clk);
        chk("expq_empty", expq.size(), 0);
        chk("arq_empty", arq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
